mem_access_unit: RTL and testbench
==================================

# mem_access_unit

Load/store controller between the pipeline MEM stage and the `ram256x8` data memory. It accepts one request at a time over a valid/ready handshake. It drives the RAM's Enable/ReadWrite/Address/DataIn/Size for a programmable number of cycles, then returns a registered, sign- or zero-extended load result or store acknowledge. It also validates access size and alignment before the RAM is touched.

## Interface
- `ADDR_W`, 8: byte-address width into the RAM.
- `WAIT_CYCLES`, 1: cycles the RAM access is held before completion. Legal values are 1..15.
- `clk`  in  1  rising-edge clock.
- `reset`  in  1  asynchronous, active-high reset.
- `req_valid`  in  1  request present.
- `req_ready`  out  1  unit can accept a request.
- `req_rw`  in  1  0 = load, 1 = store.
- `req_size`  in  2  00 byte, 01 halfword, 10 word, 11 reserved.
- `req_se`  in  1  sign-extend loads (1) or zero-extend (0).
- `req_addr`  in  ADDR_W  byte address.
- `req_wdata`  in  32  store data, right-justified.
- `resp_valid`  out  1  one-cycle response strobe.
- `resp_rdata`  out  32  extended load data; 0 for stores and errors.
- `resp_err`  out  1  request rejected (reserved size or misaligned); qualified by `resp_valid`.
- `ram_enable`  out  1  RAM Enable.
- `ram_rw`  out  1  RAM ReadWrite (1 = write).
- `ram_addr`  out  ADDR_W  RAM Address.
- `ram_size`  out  2  RAM Size.
- `ram_din`  out  32  RAM DataIn.
- `ram_dout`  in  32  RAM DataOut: right-justified, zero-filled, big-endian byte order.

## Operation
- FSM states: IDLE, ACCESS, RESP.
- **IDLE**
  - `req_ready`=1.
  - On `req_valid` at a rising edge: latch rw, size, se, addr, wdata.
  - If the request is illegal: go to RESP with the error flag set. The RAM is never enabled.
  - Otherwise: load the wait counter with `WAIT_CYCLES`-1 and go to ACCESS.
- **ACCESS**
  - `ram_enable`=1. `ram_rw`, `ram_addr`, `ram_size` come from the latched request.
  - `ram_din` = wdata masked to the size: byte uses [7:0], halfword uses [15:0], upper bits are 0.
  - The counter decrements each cycle.
  - At counter=0, on the next edge:
    - Loads capture `ram_dout` into `resp_rdata`, extended from bit 7 (byte) or bit 15 (halfword) when se=1, zero-filled when se=0. Words pass unchanged.
    - Stores set `resp_rdata`=0.
  - Then go to RESP.
- **RESP**
  - `resp_valid`=1 for exactly one cycle. `req_ready`=0.
  - Return to IDLE.
- Illegal requests:
  - `req_size`=11 is always illegal.
  - Misalignment (halfword with addr[0]≠0, word with addr[1:0]≠0) is illegal only when alignment checking is compiled in (see Configuration).
- `ram_enable` is 0 in every state except ACCESS. Outside ACCESS, `ram_rw` is 0.
- `resp_rdata` and `resp_err` hold their value until the next response is produced.

## Timing
- Reset values: state=IDLE, `req_ready`=1, `resp_valid`=0, `resp_rdata`=0, `resp_err`=0, `ram_enable`=0, `ram_rw`=0, `ram_addr`=0, `ram_size`=0, `ram_din`=0.
- Legal request accepted at edge E:
  - `ram_enable` is high in cycles E+1 .. E+`WAIT_CYCLES`.
  - `resp_valid` is high in cycle E+`WAIT_CYCLES`+1.
  - Throughput is one request per `WAIT_CYCLES`+2 cycles.
- Illegal request accepted at edge E: `resp_valid` and `resp_err` are high in cycle E+1.
- `req_ready` deasserts the cycle after acceptance and reasserts the cycle after `resp_valid`. A `req_valid` arriving during ACCESS or RESP is ignored and must be held by the producer.
- `ram_dout` is sampled only at the final ACCESS edge. Its value in earlier ACCESS cycles is don't-care.
- Reset asserted mid-ACCESS:
  - All outputs go to their reset values immediately (asynchronous).
  - No response is produced.
  - A partially held store must not be completed.

## Configuration
- `MEM_ACCESS_ALIGN_CHECK_EN`
  - Defined: misaligned halfword/word requests produce `resp_err`=1 with no RAM access.
  - Undefined: misaligned requests are forwarded to the RAM as-is and complete normally with `resp_err`=0. Reserved size 11 still errors in both builds.

## Test plan
- RAM preloaded with bytes 8A 3B F0 C2 at 0..3, `WAIT_CYCLES`=1:
  - byte load at addr 0, se=0 → `resp_rdata`=0x0000008A, `resp_valid` two cycles after accept;
  - same load with se=1 → 0xFFFFFF8A.
- Halfword load at addr 2, se=1 → 0xFFFFF0C2; se=0 → 0x0000F0C2. Word load at 0 → 0x8A3BF0C2.
- Store word 0xABCDEF01 at addr 8, then store byte 0x1A6 at addr 0, then word load at 8 → 0xABCDEF01. During the byte store `ram_din`=0x000000A6; a word load at 0 afterwards → 0xA63BF0C2.
- With `MEM_ACCESS_ALIGN_CHECK_EN`: halfword load at addr 1 → `resp_err`=1, `resp_rdata`=0, `ram_enable` never asserted, response one cycle after accept. Without the macro: same request → `resp_err`=0. Size 11 → `resp_err`=1 in both builds.
- `WAIT_CYCLES`=3:
  - store held with `ram_enable` high for exactly 3 cycles;
  - `req_valid` held during busy is accepted only after the RESP cycle.
- `WAIT_CYCLES`=3, reset pulsed in the 2nd ACCESS cycle of a store to addr 4 → `ram_enable` drops immediately, no `resp_valid`, `req_ready`=1 after reset release.

Source files
------------

// File: rtl/mem_access_unit.sv
// mem_access_unit: load/store controller between the MEM stage and a ram256x8 data memory
// Request side: req_valid/req_ready handshake; req_rw, req_size, req_se, req_addr, req_wdata.
// Response side: resp_valid one-cycle strobe; resp_rdata extended load data; resp_err.
// RAM side: ram_enable, ram_rw, ram_addr, ram_size, ram_din out; ram_dout in.
// Define MEM_ACCESS_ALIGN_CHECK_EN to reject misaligned halfword/word requests.
module mem_access_unit #(
  parameter int ADDR_W      = 8,
  parameter int WAIT_CYCLES = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_rw,
  input  logic [1:0]        req_size,
  input  logic              req_se,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  output logic              resp_valid,
  output logic [31:0]       resp_rdata,
  output logic              resp_err,
  output logic              ram_enable,
  output logic              ram_rw,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [1:0]        ram_size,
  output logic [31:0]       ram_din,
  input  logic [31:0]       ram_dout
);
  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;
  state_t state, state_nx;
  logic rw, se, err, illegal, accept, done;
  logic [1:0] size;
  logic [ADDR_W-1:0] addr;
  logic [31:0] wdata, rdata, load;
  logic [3:0] cnt;
`ifdef MEM_ACCESS_ALIGN_CHECK_EN
  assign illegal = req_size == 2'b11 || (req_size == 2'b01 && req_addr[0]) ||
                   (req_size == 2'b10 && req_addr[1:0] != 2'b00);
`else
  assign illegal = req_size == 2'b11;
`endif
  assign accept     = state == IDLE && req_valid;
  assign done       = state == ACCESS && cnt == 4'd0;
  assign req_ready  = state == IDLE;
  assign resp_valid = state == RESP;
  assign ram_enable = state == ACCESS;
  assign ram_rw     = ram_enable && rw;
  assign ram_addr   = addr;
  assign ram_size   = size;
  assign ram_din    = size == 2'b00 ? {24'b0, wdata[7:0]} :
                      size == 2'b01 ? {16'b0, wdata[15:0]} : wdata;
  assign load       = size == 2'b00 ? {{24{se & ram_dout[7]}}, ram_dout[7:0]} :
                      size == 2'b01 ? {{16{se & ram_dout[15]}}, ram_dout[15:0]} : ram_dout;
  assign resp_rdata = rdata;
  assign resp_err   = err;
  always_ff @(posedge clk or posedge reset)
    if (reset) state <= IDLE;
    else state <= state_nx;
  always_comb begin
    state_nx = state;
    if (accept) state_nx = illegal ? RESP : ACCESS;
    else if (done) state_nx = RESP;
    else if (state == RESP) state_nx = IDLE;
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      rw    <= 1'b0;
      se    <= 1'b0;
      size  <= 2'b00;
      addr  <= '0;
      wdata <= 32'b0;
      cnt   <= 4'd0;
      rdata <= 32'b0;
      err   <= 1'b0;
    end else begin
      if (accept) begin
        rw    <= req_rw;
        se    <= req_se;
        size  <= req_size;
        addr  <= req_addr;
        wdata <= req_wdata;
        cnt   <= 4'(WAIT_CYCLES - 1);
        if (illegal) begin
          rdata <= 32'b0;
          err   <= 1'b1;
        end
      end else if (state == ACCESS) cnt <= cnt - 4'd1;
      if (done) begin
        rdata <= rw ? 32'b0 : load;
        err   <= 1'b0;
      end
    end
endmodule

// File: tb/tb_mem_access_unit.sv
// tb_mem_access_unit: directed scoreboard bench for mem_access_unit with a ram256x8 model
module tb_mem_access_unit;
  logic clk = 1'b0, reset = 1'b1, sel = 1'b0;
  logic req_valid = 1'b0, req_rw = 1'b0, req_se = 1'b0;
  logic [1:0] req_size = 2'b00;
  logic [7:0] req_addr = 8'h00;
  logic [31:0] req_wdata = 32'h0;
  logic rdy_a, rv_a, er_a, en_a, rw_a, rdy_b, rv_b, er_b, en_b, rw_b;
  logic [31:0] rd_a, din_a, rd_b, din_b, ram_dout;
  logic [7:0] ad_a, ad_b;
  logic [1:0] sz_a, sz_b;
  logic rdy, rv, er, en_m, rw_m;
  logic [31:0] rd, din_m;
  logic [7:0] ad_m;
  logic [1:0] sz_m;
  logic [7:0] mem [256];
  logic [32:0] sb [$];
  int checks = 0, errors = 0;
  always #5 clk = ~clk;
  mem_access_unit #(.ADDR_W(8), .WAIT_CYCLES(1)) dut_a (
    .clk(clk), .reset(reset), .req_valid(req_valid & ~sel), .req_ready(rdy_a), .req_rw(req_rw),
    .req_size(req_size), .req_se(req_se), .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(rv_a), .resp_rdata(rd_a), .resp_err(er_a), .ram_enable(en_a), .ram_rw(rw_a),
    .ram_addr(ad_a), .ram_size(sz_a), .ram_din(din_a), .ram_dout(ram_dout));
  mem_access_unit #(.ADDR_W(8), .WAIT_CYCLES(3)) dut_b (
    .clk(clk), .reset(reset), .req_valid(req_valid & sel), .req_ready(rdy_b), .req_rw(req_rw),
    .req_size(req_size), .req_se(req_se), .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(rv_b), .resp_rdata(rd_b), .resp_err(er_b), .ram_enable(en_b), .ram_rw(rw_b),
    .ram_addr(ad_b), .ram_size(sz_b), .ram_din(din_b), .ram_dout(ram_dout));
  assign rdy   = sel ? rdy_b : rdy_a;
  assign rv    = sel ? rv_b : rv_a;
  assign er    = sel ? er_b : er_a;
  assign rd    = sel ? rd_b : rd_a;
  assign en_m  = sel ? en_b : en_a;
  assign rw_m  = sel ? rw_b : rw_a;
  assign ad_m  = sel ? ad_b : ad_a;
  assign sz_m  = sel ? sz_b : sz_a;
  assign din_m = sel ? din_b : din_a;
  always_comb
    ram_dout = sz_m == 2'b00 ? {24'b0, mem[ad_m]} :
               sz_m == 2'b01 ? {16'b0, mem[ad_m], mem[ad_m + 8'd1]} :
               {mem[ad_m], mem[ad_m + 8'd1], mem[ad_m + 8'd2], mem[ad_m + 8'd3]};
  always @(posedge clk)
    if (en_m && rw_m) begin
      if (sz_m == 2'b00) mem[ad_m] <= din_m[7:0];
      else if (sz_m == 2'b01) begin
        mem[ad_m] <= din_m[15:8];
        mem[ad_m + 8'd1] <= din_m[7:0];
      end else begin
        mem[ad_m] <= din_m[31:24];
        mem[ad_m + 8'd1] <= din_m[23:16];
        mem[ad_m + 8'd2] <= din_m[15:8];
        mem[ad_m + 8'd3] <= din_m[7:0];
      end
    end
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask
  task automatic pop_cmp(input string tag);
    logic [32:0] x;
    x = sb.pop_front();
    chk({tag, " rdata"}, rd, x[31:0]);
    chk({tag, " err"}, 32'(er), 32'(x[32]));
  endtask
  task automatic issue(input string tag, input logic rw, input logic [1:0] sz, input logic se,
                       input logic [7:0] a, input logic [31:0] wd, input logic [31:0] xd,
                       input logic xe, input int xlat, input int xen, output logic [31:0] din);
    int n, en;
    din = 32'h0;
    @(negedge clk);
    req_valid = 1'b1; req_rw = rw; req_size = sz; req_se = se; req_addr = a; req_wdata = wd;
    n = 0;
    while (!rdy && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk({tag, " ready"}, 32'(rdy), 32'd1);
    @(negedge clk);
    req_valid = 1'b0;
    sb.push_back({xe, xd});
    n = 1;
    en = 0;
    while (!rv && n < 40) begin
      if (en_m) begin
        en++;
        din = din_m;
      end
      @(negedge clk);
      n++;
    end
    chk({tag, " latency"}, n, xlat);
    chk({tag, " enable cycles"}, en, xen);
    chk({tag, " ready in resp"}, 32'(rdy), 32'd0);
    pop_cmp(tag);
  endtask
  initial begin
    logic [31:0] d;
    int busy, resp;
    for (int i = 0; i < 256; i++) mem[i] <= 8'h00;
    #1;
    mem[0] <= 8'h8A; mem[1] <= 8'h3B; mem[2] <= 8'hF0; mem[3] <= 8'hC2;
    #11;
    chk("reset ready", 32'(rdy), 32'd1);
    chk("reset resp_valid", 32'(rv), 32'd0);
    chk("reset rdata", rd, 32'd0);
    chk("reset err", 32'(er), 32'd0);
    chk("reset ram_enable", 32'(en_m), 32'd0);
    chk("reset ram_rw/addr/size", {rw_m, ad_m, sz_m}, 32'd0);
    chk("reset ram_din", din_m, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    issue("lb zx", 1'b0, 2'b00, 1'b0, 8'd0, 32'h0, 32'h0000008A, 1'b0, 2, 1, d);
    issue("lb sx", 1'b0, 2'b00, 1'b1, 8'd0, 32'h0, 32'hFFFFFF8A, 1'b0, 2, 1, d);
    issue("lh sx", 1'b0, 2'b01, 1'b1, 8'd2, 32'h0, 32'hFFFFF0C2, 1'b0, 2, 1, d);
    issue("lh zx", 1'b0, 2'b01, 1'b0, 8'd2, 32'h0, 32'h0000F0C2, 1'b0, 2, 1, d);
    issue("lw 0", 1'b0, 2'b10, 1'b0, 8'd0, 32'h0, 32'h8A3BF0C2, 1'b0, 2, 1, d);
    issue("sw 8", 1'b1, 2'b10, 1'b0, 8'd8, 32'hABCDEF01, 32'h0, 1'b0, 2, 1, d);
    chk("sw 8 din", d, 32'hABCDEF01);
    issue("sb 0", 1'b1, 2'b00, 1'b0, 8'd0, 32'h000001A6, 32'h0, 1'b0, 2, 1, d);
    chk("sb 0 din", d, 32'h000000A6);
    issue("lw 8", 1'b0, 2'b10, 1'b0, 8'd8, 32'h0, 32'hABCDEF01, 1'b0, 2, 1, d);
    issue("lw 0 after sb", 1'b0, 2'b10, 1'b0, 8'd0, 32'h0, 32'hA63BF0C2, 1'b0, 2, 1, d);
`ifdef MEM_ACCESS_ALIGN_CHECK_EN
    issue("lh misaligned", 1'b0, 2'b01, 1'b0, 8'd1, 32'h0, 32'h0, 1'b1, 1, 0, d);
`else
    issue("lh misaligned", 1'b0, 2'b01, 1'b0, 8'd1, 32'h0, 32'h00003BF0, 1'b0, 2, 1, d);
`endif
    issue("size 11", 1'b0, 2'b11, 1'b0, 8'd0, 32'h0, 32'h0, 1'b1, 1, 0, d);
    issue("lb after err", 1'b0, 2'b00, 1'b1, 8'd2, 32'h0, 32'hFFFFFFF0, 1'b0, 2, 1, d);
    @(negedge clk);
    sel = 1'b1;
    issue("w3 sw 16", 1'b1, 2'b10, 1'b0, 8'd16, 32'h11223344, 32'h0, 1'b0, 4, 3, d);
    issue("w3 lh 16", 1'b0, 2'b01, 1'b1, 8'd16, 32'h0, 32'h00001122, 1'b0, 4, 3, d);
    @(negedge clk);
    req_valid = 1'b1; req_rw = 1'b1; req_size = 2'b10; req_se = 1'b0; req_addr = 8'd20;
    req_wdata = 32'h55667788;
    sb.push_back({1'b0, 32'h0});
    @(negedge clk);
    busy = 0;
    resp = 0;
    while (!rdy && busy < 20) begin
      busy++;
      if (rv) begin
        resp++;
        pop_cmp("hold first");
      end
      @(negedge clk);
    end
    chk("hold busy cycles", busy, 4);
    chk("hold resp count", resp, 1);
    sb.push_back({1'b0, 32'h0});
    @(negedge clk);
    req_valid = 1'b0;
    chk("hold second accepted", 32'(rdy), 32'd0);
    busy = 0;
    while (!rv && busy < 20) begin
      busy++;
      @(negedge clk);
    end
    chk("hold second latency", busy, 3);
    pop_cmp("hold second");
    chk("hold mem", {mem[20], mem[21], mem[22], mem[23]}, 32'h55667788);
    @(negedge clk);
    req_valid = 1'b1; req_rw = 1'b1; req_size = 2'b10; req_addr = 8'd4; req_wdata = 32'hDEADBEEF;
    @(negedge clk);
    req_valid = 1'b0;
    @(negedge clk);
    chk("rst mid enable before", 32'(en_m), 32'd1);
    reset = 1'b1;
    #1;
    chk("rst mid enable drop", 32'(en_m), 32'd0);
    chk("rst mid ram_rw", 32'(rw_m), 32'd0);
    chk("rst mid ram_din", din_m, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    resp = 0;
    for (int i = 0; i < 8; i++) begin
      resp += 32'(rv);
      @(negedge clk);
    end
    chk("rst mid no resp", resp, 0);
    chk("rst mid ready", 32'(rdy), 32'd1);
    chk("scoreboard empty", sb.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
